systolic_buffer_reader: RTL

//  Read side of the A/B operand buffers. Once the controller raises array_start, the block reads A
//  and B words from the buffers, tile by tile, and streams matched A/B pairs into the systolic array.
//  It does not read a word until the write side reports that word written, and it pulses data_done

---
 rtl/systolic_buffer_reader_if.sv | 35 +++
 rtl/systolic_buffer_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_buffer_reader_if.sv
// Operand-buffer read / array-feed bundle: master is systolic_buffer_reader, slave is its environment.
// SA_READER_PERF_EN adds the stall_cycles / ready_stalls counter outputs.
interface systolic_buffer_reader_if #(
  parameter int BAW = 10
);
  logic           array_start;
  logic [15:0]    m, n, p;
  logic [15:0]    a_global_counts, b_global_counts;
  logic           a_rd_en, b_rd_en;
  logic [BAW-1:0] a_rd_addr, b_rd_addr;
  logic           array_ready;
  logic           feed_valid, feed_first, feed_last;
  logic           tile_done, data_done;
`ifdef SA_READER_PERF_EN
  logic [31:0]    stall_cycles, ready_stalls;
`endif

  modport master (
    input  array_start, m, n, p, a_global_counts, b_global_counts, array_ready,
    output a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, feed_valid, feed_first, feed_last,
           tile_done, data_done
`ifdef SA_READER_PERF_EN
           , stall_cycles, ready_stalls
`endif
  );

  modport slave (
    output array_start, m, n, p, a_global_counts, b_global_counts, array_ready,
    input  a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, feed_valid, feed_first, feed_last,
           tile_done, data_done
`ifdef SA_READER_PERF_EN
           , stall_cycles, ready_stalls
`endif
  );
endinterface

// File: rtl/systolic_buffer_reader.sv
// Tile-by-tile A/B buffer reader feeding the systolic array: rd_en 1 cycle after start, feed 1 cycle later.
// array_ready low holds up to 2 in-flight beats in a tag skid, then reads stall; SA_READER_PERF_EN adds counters.
module systolic_buffer_reader #(
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int ARRAY_HEIGHT         = 4,
  parameter int ARRAY_WIDTH          = 4,
  parameter int DRAIN_CYCLES         = ARRAY_HEIGHT + ARRAY_WIDTH - 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  systolic_buffer_reader_if.master bus
);
  localparam int          AH_SH     = $clog2(ARRAY_HEIGHT);
  localparam int          AW_SH     = $clog2(ARRAY_WIDTH);
  localparam logic [31:0] DRAIN_LEN = DRAIN_CYCLES;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t      state;
  logic        array_start_q;
  logic [15:0] n_q, k_q;
  logic [16:0] mt_q, pt_q, ti_q, tj_q;
  logic        issued_all;
  logic [31:0] a_base, b_base, drain_cnt;
  logic [1:0]  sk_cnt, sk_first, sk_last;
  logic        tile_done_q, data_done_q;

  logic        start, zero_dim, issue, pop, new_first, new_last;
  logic [16:0] mt_full, pt_full;
  logic [31:0] a_idx, b_idx;

  assign start     = bus.array_start & ~array_start_q;
  assign zero_dim  = (bus.m == 16'd0) | (bus.n == 16'd0) | (bus.p == 16'd0);
  assign mt_full   = ({1'b0, bus.m} + 17'(ARRAY_HEIGHT - 1)) >> AH_SH;
  assign pt_full   = ({1'b0, bus.p} + 17'(ARRAY_WIDTH - 1)) >> AW_SH;
  assign a_idx     = a_base + {16'd0, k_q};
  assign b_idx     = b_base + {16'd0, k_q};
  assign new_first = (k_q == 16'd0);
  assign new_last  = (k_q == n_q - 16'd1);

  // Skid occupancy counts beats already issued, so the RAM never runs more than 2 beats ahead.
  assign issue = (state == STREAM) & ~issued_all & (sk_cnt < 2'd2) &
                 (a_idx < {16'd0, bus.a_global_counts}) &
                 (b_idx < {16'd0, bus.b_global_counts});
  assign pop   = (sk_cnt != 2'd0) & bus.array_ready;

  assign bus.a_rd_en    = issue;
  assign bus.b_rd_en    = issue;
  assign bus.a_rd_addr  = a_idx[BUFFER_ADDRESS_WIDTH-1:0];
  assign bus.b_rd_addr  = b_idx[BUFFER_ADDRESS_WIDTH-1:0];
  assign bus.feed_valid = (sk_cnt != 2'd0);
  assign bus.feed_first = bus.feed_valid & sk_first[0];
  assign bus.feed_last  = bus.feed_valid & sk_last[0];
  assign bus.tile_done  = tile_done_q;
  assign bus.data_done  = data_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sk_cnt   <= 2'd0;
      sk_first <= 2'b00;
      sk_last  <= 2'b00;
    end else begin
      sk_cnt <= sk_cnt + {1'b0, issue} - {1'b0, pop};
      case ({issue, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) begin
            sk_first[0] <= new_first;
            sk_last[0]  <= new_last;
          end else begin
            sk_first[1] <= new_first;
            sk_last[1]  <= new_last;
          end
        end
        2'b01: begin
          sk_first <= {1'b0, sk_first[1]};
          sk_last  <= {1'b0, sk_last[1]};
        end
        2'b11: begin
          sk_first <= {1'b0, new_first};
          sk_last  <= {1'b0, new_last};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      array_start_q <= 1'b0;
      n_q           <= 16'd0;
      k_q           <= 16'd0;
      mt_q          <= 17'd0;
      pt_q          <= 17'd0;
      ti_q          <= 17'd0;
      tj_q          <= 17'd0;
      issued_all    <= 1'b0;
      a_base        <= 32'd0;
      b_base        <= 32'd0;
      drain_cnt     <= 32'd0;
      tile_done_q   <= 1'b0;
      data_done_q   <= 1'b0;
    end else begin
      array_start_q <= bus.array_start;
      tile_done_q   <= 1'b0;
      data_done_q   <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            n_q        <= bus.n;
            mt_q       <= mt_full;
            pt_q       <= pt_full;
            ti_q       <= 17'd0;
            tj_q       <= 17'd0;
            k_q        <= 16'd0;
            issued_all <= 1'b0;
            a_base     <= 32'd0;
            b_base     <= 32'd0;
            state      <= zero_dim ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (issue) begin
            if (new_last) issued_all <= 1'b1;
            else          k_q        <= k_q + 16'd1;
          end
          if (pop && sk_last[0]) begin
            drain_cnt <= 32'd0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // Tile order: j (B column tile) inner, i (A row tile) outer.
          if (drain_cnt + 32'd2 >= DRAIN_LEN) begin
            tile_done_q <= 1'b1;
            k_q         <= 16'd0;
            issued_all  <= 1'b0;
            if (tj_q == pt_q - 17'd1) begin
              tj_q   <= 17'd0;
              b_base <= 32'd0;
              if (ti_q == mt_q - 17'd1) begin
                state <= DONE;
              end else begin
                ti_q   <= ti_q + 17'd1;
                a_base <= a_base + {16'd0, n_q};
                state  <= STREAM;
              end
            end else begin
              tj_q   <= tj_q + 17'd1;
              b_base <= b_base + {16'd0, n_q};
              state  <= STREAM;
            end
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SA_READER_PERF_EN
  logic [31:0] stall_q, ready_stall_q;

  assign bus.stall_cycles = stall_q;
  assign bus.ready_stalls = ready_stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q       <= 32'd0;
      ready_stall_q <= 32'd0;
    end else if ((state == IDLE) && start) begin
      stall_q       <= 32'd0;
      ready_stall_q <= 32'd0;
    end else begin
      if ((state == STREAM) && !issue && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
      if (bus.feed_valid && !bus.array_ready)
        ready_stall_q <= ready_stall_q + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Write-side counts may only grow while an operation is running.
  logic        busy_q;
  logic [15:0] a_cnt_q, b_cnt_q;
  logic        busy;

  assign busy = (state == STREAM) | (state == DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      a_cnt_q <= 16'd0;
      b_cnt_q <= 16'd0;
    end else begin
      busy_q  <= busy;
      a_cnt_q <= bus.a_global_counts;
      b_cnt_q <= bus.b_global_counts;
      if (busy && busy_q) begin
        assert (bus.a_global_counts >= a_cnt_q);
        assert (bus.b_global_counts >= b_cnt_q);
      end
    end
  end
`endif
endmodule
